// File: rtl/conv2_pkg.sv
// Shared constants, data types and FSM encoding for the conv2 dual-kernel MAC stage.
package conv2_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 24;
  localparam int TAPS    = 25;
  localparam int GRP_OFF = 75;

  typedef logic signed [DATA_W-1:0] weight_t;
  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Kernel select 3 folds onto kernel 2, so group A never reaches past word 74.
  function automatic logic [7:0] kernel_base(input logic [1:0] ksel);
    case (ksel)
      2'd0:    kernel_base = 8'd0;
      2'd1:    kernel_base = 8'(TAPS);
      default: kernel_base = 8'(2 * TAPS);
    endcase
  endfunction

endpackage

// File: rtl/conv2_mac_lane.sv
// One signed multiply-accumulate lane; o_sum is the running total including this cycle's product.
module conv2_mac_lane
  import conv2_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_clear,
  input  logic    i_en,
  input  weight_t i_w,
  input  pixel_t  i_px,
  output acc_t    o_sum
);

  acc_t                      r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  acc_t                      w_prod_ext;

  always_comb begin
    w_prod     = i_w * i_px;
    w_prod_ext = {{(ACC_W - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    o_sum      = i_en ? (r_acc + w_prod_ext) : r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/conv2_dual_mac.sv
// Conv2 dual-kernel MAC stage: tap/address generator, two MAC lanes and a valid/ready output.
// Build option: define CONV2_RELU_EN to clamp negative sums to zero at the output load.
module conv2_dual_mac
  import conv2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       start,
  input  logic [1:0] kernel_sel,
  output logic [7:0] w_addr0,
  output logic [7:0] w_addr1,
  output logic [4:0] tap_idx,
  input  weight_t    w0_q,
  input  weight_t    w1_q,
  input  pixel_t     px_q,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output acc_t       sum0,
  output acc_t       sum1
);

  state_t     r_state, w_state_next;
  logic [4:0] r_tap;
  logic [7:0] r_base;
  logic       r_rd_vld;
  acc_t       r_sum0, r_sum1;
  acc_t       w_acc0, w_acc1, w_out0, w_out1;
  logic       w_issue, w_clear, w_load, w_last_tap;

  assign w_last_tap = (r_tap == 5'(TAPS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)                  w_state_next = ISSUE;
      ISSUE:   if (enable && w_last_tap)   w_state_next = DRAIN;
      DRAIN:   if (r_rd_vld)               w_state_next = HOLD;
      HOLD:    if (out_ready)              w_state_next = IDLE;
      default:                             w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    out_valid = (r_state == HOLD);
    w_issue   = (r_state == ISSUE) && enable;
    w_clear   = (r_state == IDLE) && start;
    w_load    = (r_state == DRAIN) && r_rd_vld;
  end

  // The last tap is not incremented past, so the address rests on tap 24 until the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tap    <= '0;
      r_base   <= '0;
      r_rd_vld <= 1'b0;
      r_sum0   <= '0;
      r_sum1   <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_clear) begin
        r_tap  <= '0;
        r_base <= kernel_base(kernel_sel);
      end else if (w_issue && !w_last_tap) begin
        r_tap <= r_tap + 5'd1;
      end
      if (w_load) begin
        r_sum0 <= w_out0;
        r_sum1 <= w_out1;
      end
    end
  end

  always_comb begin
    w_out0 = w_acc0;
    w_out1 = w_acc1;
`ifdef CONV2_RELU_EN
    if (w_acc0 < 0) w_out0 = '0;
    if (w_acc1 < 0) w_out1 = '0;
`endif
  end

  assign w_addr0 = r_base + {3'b000, r_tap};
  assign w_addr1 = w_addr0 + 8'(GRP_OFF);
  assign tap_idx = r_tap;
  assign sum0    = r_sum0;
  assign sum1    = r_sum1;

  conv2_mac_lane u_lane_a (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_clear (w_clear),
    .i_en    (r_rd_vld),
    .i_w     (w0_q),
    .i_px    (px_q),
    .o_sum   (w_acc0)
  );

  conv2_mac_lane u_lane_b (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_clear (w_clear),
    .i_en    (r_rd_vld),
    .i_w     (w1_q),
    .i_px    (px_q),
    .o_sum   (w_acc1)
  );

endmodule
